// File: rtl/instr_decode_stage.sv
// RV32/RV64 decode stage: combinational field/immediate decode into a 2-entry output/skid buffer.
// Latency 1 cycle into an empty output register; in_ready drops only when the skid entry is occupied.
module instr_decode_stage #(
  parameter  int XLEN    = 32,
  parameter  int PC_W    = 32,
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [2:0]         funct3,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [6:0]         funct7,
  output logic [SHAMT_W-1:0] shamt,
  output logic [11:0]        csr,
  output logic [XLEN-1:0]    imm,
  output logic [2:0]         fmt,
  output logic               illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [6:0]         funct7;
    logic [SHAMT_W-1:0] shamt;
    logic [11:0]        csr;
    logic [XLEN-1:0]    imm;
    logic [2:0]         fmt;
    logic               illegal;
  } dec_t;

  dec_t        w_dec;
  logic [2:0]  w_fmt;
  logic [31:0] w_imm32;
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1101111:             w_fmt = FMT_J;
      7'b1100011:             w_fmt = FMT_B;
      7'b0100011:             w_fmt = FMT_S;
      7'b0110011:             w_fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011: w_fmt = FMT_I;
      // Word-sized ops exist only on RV64
      7'b0011011:             w_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0111011:             w_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:                w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {in_instr[31:12], 12'd0};
      FMT_J: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  // Every immediate is 32-bit sign-extended first, then widened for RV64
  if (XLEN == 64) begin : g_imm64
    assign w_imm = {{32{w_imm32[31]}}, w_imm32};
  end else begin : g_imm32
    assign w_imm = w_imm32;
  end

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.opcode  = in_instr[6:0];
    w_dec.rd      = in_instr[11:7];
    w_dec.funct3  = in_instr[14:12];
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.funct7  = in_instr[31:25];
    w_dec.shamt   = in_instr[20 +: SHAMT_W];
    w_dec.csr     = in_instr[31:20];
    w_dec.imm     = w_imm;
    w_dec.fmt     = w_fmt;
    w_dec.illegal = (w_fmt == FMT_ILL);
  end

  dec_t r_or;
  dec_t r_sr;
  logic r_or_vld;
  logic r_sr_vld;
  logic w_accept;
  logic w_retire;

  assign w_accept = in_valid && !r_sr_vld;
  assign w_retire = r_or_vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or     <= '0;
      r_sr     <= '0;
      r_or_vld <= 1'b0;
      r_sr_vld <= 1'b0;
    end else if (flush) begin
      r_or_vld <= 1'b0;
      r_sr_vld <= 1'b0;
    end else if (w_retire) begin
      // SR valid implies in_ready was low, so no accept competes with the refill
      if (r_sr_vld) begin
        r_or     <= r_sr;
        r_or_vld <= 1'b1;
        r_sr_vld <= 1'b0;
      end else if (w_accept) begin
        r_or     <= w_dec;
        r_or_vld <= 1'b1;
      end else begin
        r_or_vld <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_or_vld) begin
        r_or     <= w_dec;
        r_or_vld <= 1'b1;
      end else begin
        r_sr     <= w_dec;
        r_sr_vld <= 1'b1;
      end
    end
  end

  assign in_ready  = !r_sr_vld;
  assign out_valid = r_or_vld;
  assign out_pc    = r_or.pc;
  assign opcode    = r_or.opcode;
  assign rd        = r_or.rd;
  assign funct3    = r_or.funct3;
  assign rs1       = r_or.rs1;
  assign rs2       = r_or.rs2;
  assign funct7    = r_or.funct7;
  assign shamt     = r_or.shamt;
  assign csr       = r_or.csr;
  assign imm       = r_or.imm;
  assign fmt       = r_or.fmt;
  assign illegal   = r_or.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: RV32 and RV64 instances, decode vectors, skid ordering, flush and async reset.
module tb_instr_decode_stage;

  logic clk;
  logic rst_n;

  // RV32 instance signals
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_shamt;
  logic [2:0]  a_funct3, a_fmt;
  logic [11:0] a_csr;

  // RV64 instance signals
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc;
  logic [63:0] b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [5:0]  b_shamt;
  logic [2:0]  b_funct3, b_fmt;
  logic [11:0] b_csr;

  int n_chk;
  int n_pass;

  instr_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2),
    .funct7(a_funct7), .shamt(a_shamt), .csr(a_csr), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal)
  );

  instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2),
    .funct7(b_funct7), .shamt(b_shamt), .csr(b_csr), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] instr, input logic [31:0] pc);
    a_in_valid = 1'b1;
    a_in_instr = instr;
    a_in_pc    = pc;
  endtask

  // Hand-decoded RV32 vectors
  logic [31:0] v_instr [8];
  logic [2:0]  v_fmt   [8];
  logic [31:0] v_imm   [8];

  initial begin
    v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'h00208033, 32'h123452B7,
                32'hFE20AC23, 32'hFFDFF06F, 32'h00000012, 32'h0000003B};
    v_fmt   = '{3'd1, 3'd3, 3'd0, 3'd4, 3'd2, 3'd5, 3'd7, 3'd7};
    v_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h12345000,
                32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h0};
    n_chk = 0;
    n_pass = 0;

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1;
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_imm", a_imm, 0);
    chk("rst_pc", a_out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode stream, one per cycle
    for (int i = 0; i < 8; i++) begin
      push32(v_instr[i], 32'h100 + 32'(4 * i));
      tick();
      chk($sformatf("v%0d_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_pc", i), a_out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d_fmt", i), a_fmt, v_fmt[i]);
      chk($sformatf("v%0d_imm", i), a_imm, v_imm[i]);
      chk($sformatf("v%0d_illegal", i), a_illegal, (v_fmt[i] == 3'd7));
      if (i == 0) begin
        chk("addi_rd", a_rd, 1);
        chk("addi_rs1", a_rs1, 0);
        chk("addi_opcode", a_opcode, 7'h13);
      end
      if (i == 2) begin
        chk("add_rs1", a_rs1, 1);
        chk("add_rs2", a_rs2, 2);
      end
    end
    a_in_valid = 0;
    tick();
    chk("drain_valid", a_out_valid, 0);

    // Skid: A, B, C with out_ready low
    a_out_ready = 0;
    push32(32'hFFF00093, 32'h200);
    tick();
    push32(32'hFE000EE3, 32'h204);
    tick();
    chk("skid_in_ready_low", a_in_ready, 0);
    chk("skid_or_is_A", a_out_pc, 32'h200);
    push32(32'h00208033, 32'h208);
    tick();
    chk("skid_C_held_ready", a_in_ready, 0);
    chk("skid_A_stable_pc", a_out_pc, 32'h200);
    chk("skid_A_stable_fmt", a_fmt, 1);
    a_out_ready = 1;
    tick();
    chk("order_B_pc", a_out_pc, 32'h204);
    chk("order_B_fmt", a_fmt, 3);
    chk("order_B_ready", a_in_ready, 1);
    tick();
    chk("order_C_valid", a_out_valid, 1);
    chk("order_C_pc", a_out_pc, 32'h208);
    a_in_valid = 0;
    tick();
    chk("order_empty", a_out_valid, 0);

    // Flush with both entries full
    a_out_ready = 0;
    push32(32'hFFF00093, 32'h300);
    tick();
    push32(32'hFE000EE3, 32'h304);
    tick();
    chk("fl_full_ready", a_in_ready, 0);
    a_flush = 1;
    push32(32'h123452B7, 32'h3FC);
    tick();
    a_flush = 0;
    a_in_valid = 0;
    a_out_ready = 1;
    chk("fl1_out_valid", a_out_valid, 0);
    chk("fl1_in_ready", a_in_ready, 1);
    tick();
    chk("fl1_nothing", a_out_valid, 0);

    // Flush must drop an accept that would otherwise land
    a_out_ready = 0;
    push32(32'hFFF00093, 32'h400);
    tick();
    a_flush = 1;
    push32(32'hFE20AC23, 32'h404);
    tick();
    a_flush = 0;
    a_in_valid = 0;
    a_out_ready = 1;
    chk("fl2_out_valid", a_out_valid, 0);
    chk("fl2_in_ready", a_in_ready, 1);
    tick();
    chk("fl2_nothing", a_out_valid, 0);

    // Async reset with SR occupied
    a_out_ready = 0;
    push32(32'hFFF00093, 32'h500);
    tick();
    push32(32'hFE000EE3, 32'h504);
    tick();
    a_in_valid = 0;
    chk("ar_sr_full", a_in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", a_out_valid, 0);
    chk("ar_in_ready", a_in_ready, 1);
    chk("ar_pc_zero", a_out_pc, 0);
    chk("ar_imm_zero", a_imm, 0);
    #1;
    rst_n = 1'b1;
    a_out_ready = 1;
    push32(32'hFE000EE3, 32'h600);
    tick();
    a_in_valid = 0;
    chk("resume_valid", a_out_valid, 1);
    chk("resume_pc", a_out_pc, 32'h600);

    // RV64 checks
    b_in_valid = 1; b_in_instr = 32'h02111113; b_in_pc = 32'h700;
    tick();
    chk("rv64_slli_valid", b_out_valid, 1);
    chk("rv64_slli_shamt", b_shamt, 33);
    chk("rv64_slli_fmt", b_fmt, 1);
    chk("rv64_slli_rd", b_rd, 2);
    chk("rv64_slli_imm", b_imm, 64'd33);
    b_in_instr = 32'h00000000; b_in_pc = 32'h704;
    tick();
    chk("rv64_zero_illegal", b_illegal, 1);
    chk("rv64_zero_fmt", b_fmt, 7);
    chk("rv64_zero_imm", b_imm, 0);
    b_in_instr = 32'h0000003B; b_in_pc = 32'h708;
    tick();
    chk("rv64_addw_fmt", b_fmt, 0);
    chk("rv64_addw_illegal", b_illegal, 0);
    b_in_instr = 32'hFFF00093; b_in_pc = 32'h70C;
    tick();
    chk("rv64_addi_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rv64_addi_pc", b_out_pc, 32'h70C);
    b_in_valid = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
